// File: rtl/final_soc_sw_pkg.sv
// Shared register map and helpers for the board switch controller.
package final_soc_sw_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RAW  = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    // Bits needed to hold 0..value-1; never returns less than 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (((value - 1) >> i) != 0) begin
                result = i + 1;
            end
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

// File: rtl/final_soc_sw_debounce.sv
// One switch bit: 2-flop synchroniser, tick-driven debounce counter and accepted level.
module final_soc_sw_debounce
    import final_soc_sw_pkg::*;
#(
    parameter int unsigned DEB_SAMPLES = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic sw,
    output logic raw,
    output logic deb,
    output logic change
);

    localparam int unsigned CW = clog2(DEB_SAMPLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_SAMPLES - 1);

    logic          meta_q;
    logic          raw_q;
    logic          deb_q, deb_d;
    logic          change_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;

    // A level is accepted only on the DEB_SAMPLES-th consecutive disagreeing tick.
    always_comb begin
        accept = tick && (raw_q != deb_q) && (cnt_q >= CNT_LAST);
        cnt_d  = cnt_q;
        deb_d  = deb_q;
        if (tick) begin
            if (raw_q == deb_q) begin
                cnt_d = '0;
            end else if (accept) begin
                deb_d = raw_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q   <= 1'b0;
            raw_q    <= 1'b0;
            deb_q    <= 1'b0;
            cnt_q    <= '0;
            change_q <= 1'b0;
        end else begin
            meta_q   <= sw;
            raw_q    <= meta_q;
            deb_q    <= deb_d;
            cnt_q    <= cnt_d;
            change_q <= accept;
        end
    end

    assign raw    = raw_q;
    assign deb    = deb_q;
    assign change = change_q;

endmodule

// File: rtl/final_soc_sw_ctrl.sv
// Avalon-MM switch controller: debounced data, raw, irq mask and W1C edge registers.
// Define FINAL_SOC_SW_CTRL_IRQ_EN to build the mask register and the irq output.
module final_soc_sw_ctrl
    import final_soc_sw_pkg::*;
#(
    parameter int unsigned WIDTH       = 10,
    parameter int unsigned TICK_CYCLES = 50000,
    parameter int unsigned DEB_SAMPLES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int unsigned PW = clog2(TICK_CYCLES);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);

    logic [PW-1:0]    pre_q;
    logic             tick;
    logic [WIDTH-1:0] raw, deb, change;
    logic [WIDTH-1:0] edge_q, edge_d, edge_clr;
    logic [WIDTH-1:0] rd_sel;
    logic [WIDTH-1:0] mask_val;
    logic             wr_en;
    logic             unused_wdata;

    assign tick         = (pre_q == PRE_LAST);
    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata[31:WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= tick ? '0 : pre_q + 1'b1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        final_soc_sw_debounce #(
            .DEB_SAMPLES(DEB_SAMPLES)
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .tick  (tick),
            .sw    (in_port[i]),
            .raw   (raw[i]),
            .deb   (deb[i]),
            .change(change[i])
        );
    end

    // A new change outranks a simultaneous write-1-to-clear.
    always_comb begin
        edge_clr = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
        edge_d   = (edge_q & ~edge_clr) | change;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            edge_q <= '0;
        end else begin
            edge_q <= edge_d;
        end
    end

`ifdef FINAL_SOC_SW_CTRL_IRQ_EN
    logic [WIDTH-1:0] mask_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= '0;
            irq    <= 1'b0;
        end else begin
            if (wr_en && address == ADDR_MASK) begin
                mask_q <= writedata[WIDTH-1:0];
            end
            irq <= |(edge_q & mask_q);
        end
    end

    assign mask_val = mask_q;
`else
    assign mask_val = '0;
    assign irq      = 1'b0;
`endif

    always_comb begin
        rd_sel = '0;
        unique case (address)
            ADDR_DATA: rd_sel = deb;
            ADDR_RAW:  rd_sel = raw;
            ADDR_MASK: rd_sel = mask_val;
            ADDR_EDGE: rd_sel = edge_q;
            default:   rd_sel = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= chipselect ? 32'(rd_sel) : 32'd0;
        end
    end

endmodule

// File: tb/tb_final_soc_sw_ctrl.sv
// Self-checking bench: directed scenarios plus random bus/switch traffic against a
// cycle-level behavioural model of the switch controller.
module tb_final_soc_sw_ctrl;

    localparam int W  = 10;
    localparam int TK = 4;
    localparam int DS = 3;
`ifdef FINAL_SOC_SW_CTRL_IRQ_EN
    localparam bit MASK_EN = 1'b1;
`else
    localparam bit MASK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic [W-1:0]  in_port = '0;
    logic          irq;

    int total = 0;
    int bad   = 0;

    // Behavioural model state.
    logic [W-1:0] m_sync, m_raw, m_deb, m_chg, m_edge, m_mask;
    logic         m_irq;
    logic [31:0]  m_rd;
    int           m_cyc;
    int           m_streak[W];

    final_soc_sw_ctrl #(
        .WIDTH      (W),
        .TICK_CYCLES(TK),
        .DEB_SAMPLES(DS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs the DUT sampled at that edge.
    task automatic model_clock(input logic r, input logic [1:0] a, input logic cs,
                               input logic wn, input logic [31:0] wd, input logic [W-1:0] sw);
        logic [W-1:0] n_deb, n_chg, n_edge, n_mask, clr;
        logic [31:0]  n_rd;
        logic         n_irq, tick;
        if (r) begin
            m_sync = '0; m_raw = '0; m_deb = '0; m_chg = '0; m_edge = '0; m_mask = '0;
            m_irq = 1'b0; m_rd = '0; m_cyc = 0;
            for (int i = 0; i < W; i++) m_streak[i] = 0;
            return;
        end
        tick = ((m_cyc % TK) == TK - 1);
        m_cyc++;
        n_rd = '0;
        if (cs) begin
            case (a)
                2'd0: n_rd = 32'(m_deb);
                2'd1: n_rd = 32'(m_raw);
                2'd2: n_rd = MASK_EN ? 32'(m_mask) : 32'd0;
                default: n_rd = 32'(m_edge);
            endcase
        end
        n_irq  = MASK_EN && ((m_edge & m_mask) != '0);
        clr    = (cs && !wn && a == 2'd3) ? wd[W-1:0] : '0;
        n_edge = (m_edge & ~clr) | m_chg;
        n_mask = (MASK_EN && cs && !wn && a == 2'd2) ? wd[W-1:0] : m_mask;
        n_deb  = m_deb;
        n_chg  = '0;
        if (tick) begin
            for (int i = 0; i < W; i++) begin
                if (m_raw[i] == m_deb[i]) begin
                    m_streak[i] = 0;
                end else begin
                    m_streak[i]++;
                    if (m_streak[i] == DS) begin
                        n_deb[i] = m_raw[i];
                        n_chg[i] = 1'b1;
                        m_streak[i] = 0;
                    end
                end
            end
        end
        m_raw = m_sync; m_sync = sw;
        m_deb = n_deb; m_chg = n_chg; m_edge = n_edge; m_mask = n_mask;
        m_irq = n_irq; m_rd = n_rd;
    endtask

    task automatic step();
        logic r, cs, wn;
        logic [1:0]   a;
        logic [31:0]  wd;
        logic [W-1:0] sw;
        r = reset; a = address; cs = chipselect; wn = write_n; wd = writedata; sw = in_port;
        @(posedge clk);
        #1;
        model_clock(r, a, cs, wn, wd, sw);
        check("readdata", readdata, m_rd);
        check("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] data);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        step();
        data = readdata;
        chipselect = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        logic [31:0] v;
        int          k;

        // Reset
        reset = 1'b1;
        steps(3);
        check("rst_readdata", readdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        reset = 1'b0;
        rd(2'd0, v);
        check("rst_data", v, 32'd0);

        // Clean press on sw0
        in_port = 10'h001;
        steps(2);
        rd(2'd1, v);
        check("press_raw", v, 32'h1);
        for (k = 0; k < 40 && !m_deb[0]; k++) step();
        check("press_deb_seen", 32'(m_deb[0]), 32'd1);
        step();
        rd(2'd3, v);
        check("press_edge", v & 32'h1, 32'h1);
        rd(2'd0, v);
        check("press_data", v & 32'h1, 32'h1);

        // Glitch on sw3 lasting two ticks
        in_port[3] = 1'b1;
        steps(2 * TK);
        in_port[3] = 1'b0;
        steps(6 * TK);
        rd(2'd0, v);
        check("glitch_deb", v & 32'h8, 32'h0);
        rd(2'd3, v);
        check("glitch_edge", v & 32'h8, 32'h0);

        // IRQ: release sw0, clear edges, enable mask, press again
        in_port[0] = 1'b0;
        steps(20);
        wr(2'd3, 32'h3ff);
        wr(2'd2, 32'h001);
        rd(2'd2, v);
        check("mask_read", v, MASK_EN ? 32'h1 : 32'h0);
        in_port[0] = 1'b1;
        for (k = 0; k < 40 && !(m_edge[0]); k++) step();
        check("irq_edge_seen", 32'(m_edge[0]), 32'd1);
        step();
        check("irq_set", 32'(irq), MASK_EN ? 32'd1 : 32'd0);
        wr(2'd3, 32'h001);
        step();
        check("irq_clr", 32'(irq), 32'd0);
        rd(2'd3, v);
        check("edge_clr", v & 32'h1, 32'h0);

        // Collision: W1C on edge[5] in the cycle its change lands
        wr(2'd3, 32'h3ff);
        in_port[5] = 1'b1;
        for (k = 0; k < 40 && !m_deb[5]; k++) step();
        check("coll_deb_seen", 32'(m_deb[5]), 32'd1);
        wr(2'd3, 32'h020);
        rd(2'd3, v);
        check("coll_edge", v & 32'h20, 32'h20);

        // Reset after two of three ticks discards the partial count
        in_port[7] = 1'b1;
        for (k = 0; k < 40 && m_streak[7] != 2; k++) step();
        check("mid_streak_seen", 32'(m_streak[7]), 32'd2);
        reset = 1'b1;
        steps(2);
        reset = 1'b0;
        steps(8);
        rd(2'd0, v);
        check("mid_deb_held", v & 32'h80, 32'h0);
        steps(12);
        rd(2'd0, v);
        check("mid_deb_after", v & 32'h80, 32'h80);

        // Random switch and bus traffic
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(39) == 0) in_port[b] = ~in_port[b];
            end
            chipselect = 1'($urandom);
            write_n    = ($urandom_range(3) != 0);
            address    = 2'($urandom);
            writedata  = $urandom;
            if (n % 500 == 499) reset = 1'b1;
            else reset = 1'b0;
            step();
        end
        reset = 1'b0;
        chipselect = 1'b0;
        write_n = 1'b1;
        steps(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
